// File: rtl/imem_loader.sv
// Boot-time loader: byte stream -> little-endian 32-bit words -> instruction memory, holding the core in reset until loaded.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the image.
module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              reload,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              proc_rst,
   output logic              done,
   output logic              err
);

   localparam int WC_W = ADDR_W + 16;

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_DATA,
`ifdef LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_DONE,
      S_ERR
   } state_t;

   state_t            state_q, state_d;
   state_t            tail_state;
   logic              done_q, err_q, prst_q;
   logic [15:0]       len_q, len_d;
   logic [23:0]       asm_q, asm_d;
   logic [1:0]        bcnt_q, bcnt_d;
   logic [WC_W-1:0]   wcnt_q, wcnt_d, wcnt_inc;
   logic              ovf_q, ovf_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   logic fire, restart, in_range, last_word, word_end;

   assign fire      = in_valid & in_ready;
   assign restart   = reload & ((state_q == S_DONE) | (state_q == S_ERR));
   assign wcnt_inc  = wcnt_q + WC_W'(1);
   // Word indices past the memory depth are consumed but never written.
   assign in_range  = (wcnt_q[WC_W-1:ADDR_W] == '0);
   assign last_word = (wcnt_inc == {{ADDR_W{1'b0}}, len_q});
   assign word_end  = fire & (state_q == S_DATA) & (bcnt_q == 2'd3);

`ifdef LOADER_CHECKSUM_EN
   assign tail_state = S_CHK;
`else
   assign tail_state = (ovf_q | ~in_range) ? S_ERR : S_DONE;
`endif

   // State register; status outputs are registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_HDR0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         prst_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         done_q  <= (state_d == S_DONE);
         err_q   <= (state_d == S_ERR);
         prst_q  <= (state_d != S_DONE);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_HDR0: if (fire) state_d = S_HDR1;
         S_HDR1: if (fire) state_d = ({in_data, len_q[7:0]} == 16'd0) ? tail_state : S_DATA;
         S_DATA: if (word_end && last_word) state_d = tail_state;
`ifdef LOADER_CHECKSUM_EN
         S_CHK:  if (fire) state_d = (ovf_q || (in_data != csum_q)) ? S_ERR : S_DONE;
`endif
         S_DONE: if (reload) state_d = S_HDR0;
         S_ERR:  if (reload) state_d = S_HDR0;
         default: state_d = S_HDR0;
      endcase
   end

   always_comb begin
      in_ready  = (state_q != S_DONE) && (state_q != S_ERR);
      done      = done_q;
      err       = err_q;
      proc_rst  = prst_q;
      mem_we    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
   end

   always_comb begin
      len_d   = len_q;
      asm_d   = asm_q;
      bcnt_d  = bcnt_q;
      wcnt_d  = wcnt_q;
      ovf_d   = ovf_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      if (restart) begin
         bcnt_d = '0;
         wcnt_d = '0;
         ovf_d  = 1'b0;
         addr_d = '0;
`ifdef LOADER_CHECKSUM_EN
         csum_d = '0;
`endif
      end else if (fire) begin
`ifdef LOADER_CHECKSUM_EN
         if (state_q != S_CHK) csum_d = csum_q ^ in_data;
`endif
         case (state_q)
            S_HDR0: len_d[7:0]  = in_data;
            S_HDR1: len_d[15:8] = in_data;
            S_DATA: begin
               // Lower three bytes of the word accumulate here; the 4th arrives live.
               asm_d  = {in_data, asm_q[23:8]};
               bcnt_d = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  wcnt_d = wcnt_inc;
                  if (in_range) begin
                     we_d    = 1'b1;
                     addr_d  = wcnt_q[ADDR_W-1:0];
                     wdata_d = {in_data, asm_q};
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bcnt_q  <= '0;
         wcnt_q  <= '0;
         ovf_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         bcnt_q  <= bcnt_d;
         wcnt_q  <= wcnt_d;
         ovf_q   <= ovf_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      len_q <= len_d;
      asm_q <= asm_d;
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (ADDR_W=2): stream-level model compared every cycle plus literal expectations.
`timescale 1ns/1ps
module tb_imem_loader;

   localparam int AW    = 2;
   localparam int DEPTH = 1 << AW;
`ifdef LOADER_CHECKSUM_EN
   localparam int CSUM_BYTES = 1;
`else
   localparam int CSUM_BYTES = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          reload = 1'b0;
   logic          in_ready, mem_we, proc_rst, done, err;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;

   imem_loader #(.ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .proc_rst(proc_rst), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      else n_pass++;
   endtask

   // Inputs as seen by the DUT on the last rising edge.
   logic       s_seen = 1'b0;
   logic       s_rst, s_valid, s_reload;
   logic [7:0] s_data;
   always @(posedge clk) begin
      s_seen   <= 1'b1;
      s_rst    <= rst;
      s_valid  <= in_valid;
      s_data   <= in_data;
      s_reload <= reload;
   end

   // Model: m_k counts bytes of the current image, m_status 0=loading 1=done 2=error.
   int          m_k = 0, m_n = 0, m_status = 0, m_idx, m_lane;
   logic [31:0] m_word = 0;
   logic [7:0]  m_xor = 0;
   bit          e_we;
   int          e_addr;
   logic [31:0] e_wdata;

   int          wr_cnt = 0;
   int          wr_addr[64];
   logic [31:0] wr_data[64];
   bit          wr_done[64];

   always @(negedge clk) begin
      if (s_seen) begin
         e_we = 1'b0;
         if (s_rst) begin
            m_status = 0; m_k = 0; m_n = 0; m_xor = 0; m_word = 0;
         end else if (m_status != 0) begin
            if (s_reload) begin
               m_status = 0; m_k = 0; m_n = 0; m_xor = 0; m_word = 0;
            end
         end else if (s_valid) begin
            m_xor ^= s_data;
            if (m_k == 0) m_n = int'(s_data);
            else if (m_k == 1) m_n = m_n + 256 * int'(s_data);
            else if (m_k < 2 + 4 * m_n) begin
               m_idx  = (m_k - 2) / 4;
               m_lane = (m_k - 2) % 4;
               m_word = m_word | (32'(s_data) << (8 * m_lane));
               if (m_lane == 3) begin
                  if (m_idx < DEPTH) begin
                     e_we = 1'b1; e_addr = m_idx; e_wdata = m_word;
                  end
                  m_word = 0;
               end
            end
            m_k++;
            if (m_k == 2 + 4 * m_n + CSUM_BYTES)
               m_status = (m_n > DEPTH || (CSUM_BYTES == 1 && m_xor != 8'h00)) ? 2 : 1;
         end

         check("in_ready", {31'b0, in_ready}, {31'b0, m_status == 0});
         check("done",     {31'b0, done},     {31'b0, m_status == 1});
         check("err",      {31'b0, err},      {31'b0, m_status == 2});
         check("proc_rst", {31'b0, proc_rst}, {31'b0, m_status != 1});
         check("mem_we",   {31'b0, mem_we},   {31'b0, e_we});
         if (e_we) begin
            check("mem_addr",  32'(mem_addr), 32'(e_addr));
            check("mem_wdata", mem_wdata, e_wdata);
         end
         if (mem_we === 1'b1 && wr_cnt < 64) begin
            wr_addr[wr_cnt] = int'(mem_addr);
            wr_data[wr_cnt] = mem_wdata;
            wr_done[wr_cnt] = done;
            wr_cnt++;
         end
      end
   end

   logic [7:0] q[$];

   task automatic add_csum();
`ifdef LOADER_CHECKSUM_EN
      logic [7:0] x = 8'h00;
      foreach (q[i]) x ^= q[i];
      q.push_back(x);
`endif
   endtask

   task automatic send(input bit rnd);
      int i = 0;
      int guard = 0;
      while (i < q.size()) begin
         @(negedge clk);
         guard++;
         if (guard > 2000) begin
            check("send_timeout", 32'(i), 32'(q.size()));
            break;
         end
         if (rnd && $urandom_range(0, 1) == 0) begin
            in_valid = 1'b0;
            in_data  = 8'hEE;
         end else begin
            in_valid = 1'b1;
            in_data  = q[i];
            i++;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
   endtask

   task automatic pulse_reload();
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"},  {31'b0, in_ready}, 32'd1);
      check({tag, "_mem_we"},    {31'b0, mem_we},   32'd0);
      check({tag, "_mem_addr"},  32'(mem_addr),     32'd0);
      check({tag, "_mem_wdata"}, mem_wdata,         32'd0);
      check({tag, "_proc_rst"},  {31'b0, proc_rst}, 32'd1);
      check({tag, "_done"},      {31'b0, done},     32'd0);
      check({tag, "_err"},       {31'b0, err},      32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int base;

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_values("reset");

      // Two-word image at full rate.
      q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
      add_csum();
      send(1'b0);
      check("t1_wr_cnt",   32'(wr_cnt), 32'd2);
      check("t1_addr0",    32'(wr_addr[0]), 32'd0);
      check("t1_data0",    wr_data[0], 32'h00500013);
      check("t1_addr1",    32'(wr_addr[1]), 32'd1);
      check("t1_data1",    wr_data[1], 32'h00A00093);
      check("t1_done_at_w0", {31'b0, wr_done[0]}, 32'd0);
      check("t1_done_at_w1", {31'b0, wr_done[1]}, 32'(CSUM_BYTES == 0));
      check("t1_done",     {31'b0, done},     32'd1);
      check("t1_proc_rst", {31'b0, proc_rst}, 32'd0);
      check("t1_in_ready", {31'b0, in_ready}, 32'd0);

      // Empty image.
      pulse_reload();
      #1;
      check("t2_proc_rst_reasserted", {31'b0, proc_rst}, 32'd1);
      check("t2_done_cleared",        {31'b0, done},     32'd0);
      base = wr_cnt;
      q = '{8'h00, 8'h00};
      add_csum();
      send(1'b0);
      check("t2_done",   {31'b0, done},  32'd1);
      check("t2_no_we",  32'(wr_cnt),    32'(base));

      // Three words with a randomly gapped in_valid.
      pulse_reload();
      base = wr_cnt;
      q = '{8'h03, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
            8'h01, 8'hFF, 8'h00, 8'h00};
      add_csum();
      send(1'b1);
      check("t3_wr_cnt", 32'(wr_cnt - base), 32'd3);
      check("t3_data0",  wr_data[base],     32'h11223344);
      check("t3_data1",  wr_data[base + 1], 32'hDEADBEEF);
      check("t3_addr2",  32'(wr_addr[base + 2]), 32'd2);
      check("t3_data2",  wr_data[base + 2], 32'h0000FF01);
      check("t3_done",   {31'b0, done}, 32'd1);

      // Five words into a four-word memory.
      pulse_reload();
      base = wr_cnt;
      q = '{8'h05, 8'h00};
      for (int i = 1; i <= 20; i++) q.push_back(8'(i));
      add_csum();
      send(1'b0);
      check("t4_wr_cnt",   32'(wr_cnt - base), 32'd4);
      check("t4_data0",    wr_data[base], 32'h04030201);
      check("t4_addr3",    32'(wr_addr[base + 3]), 32'd3);
      check("t4_data3",    wr_data[base + 3], 32'h100F0E0D);
      check("t4_err",      {31'b0, err},      32'd1);
      check("t4_proc_rst", {31'b0, proc_rst}, 32'd1);
      check("t4_done",     {31'b0, done},     32'd0);

      pulse_reload();
      base = wr_cnt;
      q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00};
      add_csum();
      send(1'b0);
      check("t4r_done",  {31'b0, done}, 32'd1);
      check("t4r_err",   {31'b0, err},  32'd0);
      check("t4r_addr",  32'(wr_addr[base]), 32'd0);
      check("t4r_data",  wr_data[base], 32'h00500013);

      // Reset in the middle of a two-word image, then a clean load.
      pulse_reload();
      base = wr_cnt;
      q = '{8'h02, 8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21};
      send(1'b0);
      check("t5_partial_wr", wr_data[base], 32'h13121110);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_values("t5_rst");
      base = wr_cnt;
      q = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
      add_csum();
      send(1'b0);
      check("t5_addr0", 32'(wr_addr[base]), 32'd0);
      check("t5_data0", wr_data[base], 32'hDDCCBBAA);
      check("t5_addr1", 32'(wr_addr[base + 1]), 32'd1);
      check("t5_data1", wr_data[base + 1], 32'h04030201);
      check("t5_done",  {31'b0, done}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
      pulse_reload();
      q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h42};
      send(1'b0);
      check("t6_good_done", {31'b0, done}, 32'd1);
      check("t6_good_err",  {31'b0, err},  32'd0);
      pulse_reload();
      q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h43};
      send(1'b0);
      check("t6_bad_err",      {31'b0, err},      32'd1);
      check("t6_bad_done",     {31'b0, done},     32'd0);
      check("t6_bad_proc_rst", {31'b0, proc_rst}, 32'd1);
`endif

      repeat (3) @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
